// File: rtl/param_restoring_divider.sv
// Sequential restoring divider with start/ready handshake, optional two's-complement
// operation, and divide-by-zero / signed-overflow flags. One quotient bit per clock.
module param_restoring_divider #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             ready,
    output logic             done,
    output logic             div_by_zero,
    output logic             overflow
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] ITER = 2'd1;
    localparam logic [1:0] FIX  = 2'd2;

    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    logic [1:0]       state;
    logic [WIDTH:0]   a_reg;
    logic [WIDTH-1:0] q_reg;
    logic [WIDTH-1:0] m_reg;
    logic [CNT_W-1:0] cnt;
    logic             sign_q;
    logic             sign_r;
    logic             dbz;
    logic             ovf;

    logic [WIDTH-1:0] dvd_mag;
    logic [WIDTH-1:0] dvs_mag;
    logic [WIDTH+1:0] a_shift;
    logic [WIDTH+1:0] trial;
    logic [WIDTH-1:0] q_shift;

    // Handshake: start is sampled only on edges where ready=1 (state IDLE); done
    // pulses for exactly one cycle and coincides with ready, so a held start chains.
    assign ready = (state == IDLE);

    always_comb begin
        dvd_mag = (signed_mode && dividend[WIDTH-1]) ? -dividend : dividend;
        dvs_mag = (signed_mode && divisor[WIDTH-1])  ? -divisor  : divisor;
        // A < M holds between iterations, so the shifted A fits and the trial
        // difference is negative exactly when the subtraction must be undone.
        a_shift = {a_reg, q_reg[WIDTH-1]};
        trial   = a_shift - {2'b00, m_reg};
        q_shift = {q_reg[WIDTH-2:0], 1'b0};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            a_reg       <= '0;
            q_reg       <= '0;
            m_reg       <= '0;
            cnt         <= '0;
            sign_q      <= 1'b0;
            sign_r      <= 1'b0;
            dbz         <= 1'b0;
            ovf         <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        sign_q <= signed_mode & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                        sign_r <= signed_mode & dividend[WIDTH-1];
                        a_reg  <= '0;
                        m_reg  <= dvs_mag;
                        cnt    <= CNT_W'(WIDTH);
                        if (divisor == '0) begin
                            // Raw dividend kept in Q so it can be returned as the remainder.
                            q_reg <= dividend;
                            dbz   <= 1'b1;
                            ovf   <= 1'b0;
                            state <= FIX;
                        end else begin
                            q_reg <= dvd_mag;
                            dbz   <= 1'b0;
                            ovf   <= signed_mode && (dividend == MIN_NEG) && (divisor == '1);
                            state <= ITER;
                        end
                    end
                end
                ITER: begin
                    if (trial[WIDTH+1]) begin
                        a_reg <= a_shift[WIDTH:0];
                        q_reg <= q_shift;
                    end else begin
                        a_reg <= trial[WIDTH:0];
                        q_reg <= q_shift | {{(WIDTH-1){1'b0}}, 1'b1};
                    end
                    cnt <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    done        <= 1'b1;
                    div_by_zero <= dbz;
                    overflow    <= ovf;
                    if (dbz) begin
                        quotient  <= '1;
                        remainder <= q_reg;
                    end else if (ovf) begin
                        quotient  <= MIN_NEG;
                        remainder <= '0;
                    end else begin
                        quotient  <= sign_q ? -q_reg : q_reg;
                        remainder <= sign_r ? -a_reg[WIDTH-1:0] : a_reg[WIDTH-1:0];
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_param_restoring_divider.sv
// Bench for param_restoring_divider: 8-bit and 16-bit instances, scoreboard of
// expected {quotient, remainder, div_by_zero, overflow} checked as each op completes.
module tb_param_restoring_divider;

    localparam int W  = 8;
    localparam int W2 = 16;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic         start = 1'b0, signed_mode = 1'b0;
    logic [W-1:0] dividend = '0, divisor = '0, quotient, remainder;
    logic         ready, done, div_by_zero, overflow;

    logic          start16 = 1'b0, signed16 = 1'b0;
    logic [W2-1:0] dividend16 = '0, divisor16 = '0, quotient16, remainder16;
    logic          ready16, done16, dbz16, ovf16;

    int n_checks = 0;
    int n_fail   = 0;

    logic [2*W+1:0]  exp_q[$];
    logic [2*W2+1:0] exp16_q[$];

    param_restoring_divider #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .signed_mode(signed_mode),
        .dividend(dividend), .divisor(divisor), .quotient(quotient), .remainder(remainder),
        .ready(ready), .done(done), .div_by_zero(div_by_zero), .overflow(overflow)
    );

    param_restoring_divider #(.WIDTH(W2)) dut16 (
        .clk(clk), .rst(rst), .start(start16), .signed_mode(signed16),
        .dividend(dividend16), .divisor(divisor16), .quotient(quotient16), .remainder(remainder16),
        .ready(ready16), .done(done16), .div_by_zero(dbz16), .overflow(ovf16)
    );

    // Reference model: truncating division, remainder takes the dividend's sign.
    function automatic logic [2*W+1:0] model(input logic sm, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] q;
        logic [W-1:0] r;
        if (b == '0) return {{W{1'b1}}, a, 2'b10};
        if (sm && a == 8'h80 && b == 8'hFF) return {8'h80, 8'h00, 2'b01};
        if (sm) begin
            q = W'($signed(a) / $signed(b));
            r = W'($signed(a) % $signed(b));
        end else begin
            q = a / b;
            r = a % b;
        end
        return {q, r, 2'b00};
    endfunction

    task automatic start_op(input logic sm, input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clk);
        signed_mode = sm;
        dividend    = a;
        divisor     = b;
        start       = 1'b1;
        exp_q.push_back(model(sm, a, b));
        @(posedge clk);
        #1;
        start       = 1'b0;
        dividend    = W'($urandom);
        divisor     = W'($urandom);
        signed_mode = 1'($urandom);
    endtask

    task automatic wait_done(output int n, output logic to);
        n  = 0;
        to = 1'b1;
        while (n < 64) begin
            @(posedge clk);
            n++;
            #1;
            if (done) begin
                to = 1'b0;
                return;
            end
        end
    endtask

    task automatic test_reset();
        #12;
        n_checks++; if (ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b expected 1", ready); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
        n_checks++; if ({quotient, remainder} !== 16'h0000) begin n_fail++; $display("FAIL reset_results: got %h expected 0000", {quotient, remainder}); end
        n_checks++; if ({div_by_zero, overflow} !== 2'b00) begin n_fail++; $display("FAIL reset_flags: got %b expected 00", {div_by_zero, overflow}); end
        n_checks++; if (ready16 !== 1'b1) begin n_fail++; $display("FAIL reset_ready16: got %b expected 1", ready16); end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_unsigned();
        logic [W-1:0]   ta [0:3];
        logic [W-1:0]   tb [0:3];
        logic [W-1:0]   a, b;
        logic [2*W+1:0] exp;
        int             n;
        logic           to;
        ta = '{8'd100, 8'd255, 8'd0, 8'd37};
        tb = '{8'd7, 8'd1, 8'd9, 8'd200};
        for (int i = 0; i < 8; i++) begin
            a = (i < 4) ? ta[i] : W'($urandom_range(0, 255));
            b = (i < 4) ? tb[i] : W'($urandom_range(1, 255));
            start_op(1'b0, a, b);
            wait_done(n, to);
            exp = exp_q.pop_front();
            n_checks++; if (to || n != W + 1) begin n_fail++; $display("FAIL unsigned_latency %0d/%0d: got %0d cycles timeout=%b expected %0d", a, b, n, to, W + 1); end
            n_checks++; if ({quotient, remainder, div_by_zero, overflow} !== exp) begin n_fail++; $display("FAIL unsigned_result %0d/%0d: got %h expected %h", a, b, {quotient, remainder, div_by_zero, overflow}, exp); end
            if (i == 0) begin
                n_checks++; if ({quotient, remainder} !== {8'd14, 8'd2}) begin n_fail++; $display("FAIL unsigned_100_7: got %0d r %0d expected 14 r 2", quotient, remainder); end
                @(posedge clk); #1;
                n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL done_pulse_width: got %b expected 0", done); end
            end
        end
    endtask

    task automatic test_signed();
        logic [W-1:0]   ta [0:3];
        logic [W-1:0]   tb [0:3];
        logic [W-1:0]   a, b;
        logic [2*W+1:0] exp;
        int             n;
        logic           to;
        ta = '{8'h9C, 8'd100, 8'h9C, 8'h7F};
        tb = '{8'd7, 8'hF9, 8'hF9, 8'd2};
        for (int i = 0; i < 8; i++) begin
            a = (i < 4) ? ta[i] : W'($urandom_range(0, 255));
            b = (i < 4) ? tb[i] : W'($urandom_range(1, 254));
            start_op(1'b1, a, b);
            wait_done(n, to);
            exp = exp_q.pop_front();
            n_checks++; if (to || n != W + 1) begin n_fail++; $display("FAIL signed_latency %h/%h: got %0d cycles timeout=%b expected %0d", a, b, n, to, W + 1); end
            n_checks++; if ({quotient, remainder, div_by_zero, overflow} !== exp) begin n_fail++; $display("FAIL signed_result %h/%h: got %h expected %h", a, b, {quotient, remainder, div_by_zero, overflow}, exp); end
            if (i == 0) begin
                n_checks++; if ({quotient, remainder} !== 16'hF2FE) begin n_fail++; $display("FAIL signed_m100_7: got %h expected F2FE", {quotient, remainder}); end
            end
            if (i == 1) begin
                n_checks++; if ({quotient, remainder} !== 16'hF202) begin n_fail++; $display("FAIL signed_100_m7: got %h expected F202", {quotient, remainder}); end
            end
        end
    endtask

    task automatic test_flags();
        logic           ts [0:5];
        logic [W-1:0]   ta [0:5];
        logic [W-1:0]   tb [0:5];
        logic [2*W+1:0] exp;
        int             n;
        logic           to;
        ts = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        ta = '{8'd5, 8'd5, 8'd10, 8'h80, 8'h80, 8'd9};
        tb = '{8'd0, 8'd0, 8'd3, 8'hFF, 8'hFF, 8'd0};
        for (int i = 0; i < 6; i++) begin
            start_op(ts[i], ta[i], tb[i]);
            wait_done(n, to);
            exp = exp_q.pop_front();
            n_checks++; if (to || n != ((tb[i] == '0) ? 1 : W + 1)) begin n_fail++; $display("FAIL flags_latency op%0d: got %0d cycles timeout=%b", i, n, to); end
            n_checks++; if ({quotient, remainder, div_by_zero, overflow} !== exp) begin n_fail++; $display("FAIL flags_result op%0d sm=%b %h/%h: got %h expected %h", i, ts[i], ta[i], tb[i], {quotient, remainder, div_by_zero, overflow}, exp); end
        end
    endtask

    task automatic test_busy_ignore();
        logic [2*W+1:0] exp;
        int             n;
        logic           to;
        start_op(1'b0, 8'd200, 8'd9);
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_checks++; if (ready !== 1'b0) begin n_fail++; $display("FAIL busy_ready: got %b expected 0", ready); end
        start = 1'b1; signed_mode = 1'b1; dividend = 8'd3; divisor = 8'd0;
        repeat (2) @(negedge clk);
        start = 1'b0;
        wait_done(n, to);
        exp = exp_q.pop_front();
        n_checks++; if (to) begin n_fail++; $display("FAIL busy_timeout: got no done expected done"); end
        n_checks++; if ({quotient, remainder, div_by_zero, overflow} !== exp) begin n_fail++; $display("FAIL busy_result: got %h expected %h", {quotient, remainder, div_by_zero, overflow}, exp); end
        @(posedge clk); #1;
        n_checks++; if (done !== 1'b0 || ready !== 1'b1) begin n_fail++; $display("FAIL busy_no_extra_op: got done=%b ready=%b expected 0 1", done, ready); end
    endtask

    task automatic test_mid_reset();
        logic saw_done;
        start_op(1'b0, 8'd77, 8'd5);
        void'(exp_q.pop_back());
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        #1;
        n_checks++; if (ready !== 1'b1) begin n_fail++; $display("FAIL midreset_ready: got %b expected 1", ready); end
        n_checks++; if ({quotient, remainder, done, div_by_zero, overflow} !== 19'd0) begin n_fail++; $display("FAIL midreset_outputs: got %h expected 0", {quotient, remainder, done, div_by_zero, overflow}); end
        @(negedge clk);
        rst = 1'b1;
        saw_done = 1'b0;
        repeat (15) begin
            @(posedge clk); #1;
            if (done) saw_done = 1'b1;
        end
        n_checks++; if (saw_done !== 1'b0 || ready !== 1'b1) begin n_fail++; $display("FAIL midreset_no_done: got done_seen=%b ready=%b expected 0 1", saw_done, ready); end
    endtask

    task automatic test_back_to_back();
        logic [2*W+1:0] exp;
        int             n;
        logic           to;
        @(negedge clk);
        signed_mode = 1'b0; dividend = 8'd200; divisor = 8'd7; start = 1'b1;
        exp_q.push_back(model(1'b0, 8'd200, 8'd7));
        @(posedge clk); #1;
        dividend = 8'd50; divisor = 8'd6;
        exp_q.push_back(model(1'b0, 8'd50, 8'd6));
        wait_done(n, to);
        exp = exp_q.pop_front();
        n_checks++; if (to || n != W + 1 || ready !== 1'b1) begin n_fail++; $display("FAIL b2b_first_done: got %0d cycles timeout=%b ready=%b expected %0d 0 1", n, to, ready, W + 1); end
        n_checks++; if ({quotient, remainder, div_by_zero, overflow} !== exp) begin n_fail++; $display("FAIL b2b_first_result: got %h expected %h", {quotient, remainder, div_by_zero, overflow}, exp); end
        @(posedge clk); #1;
        start = 1'b0;
        n_checks++; if (ready !== 1'b0) begin n_fail++; $display("FAIL b2b_second_accept: got ready=%b expected 0", ready); end
        wait_done(n, to);
        exp = exp_q.pop_front();
        n_checks++; if (to || n != W + 1) begin n_fail++; $display("FAIL b2b_second_latency: got %0d cycles timeout=%b expected %0d", n, to, W + 1); end
        n_checks++; if ({quotient, remainder, div_by_zero, overflow} !== exp) begin n_fail++; $display("FAIL b2b_second_result: got %h expected %h", {quotient, remainder, div_by_zero, overflow}, exp); end
    endtask

    task automatic test_wide();
        logic [W2-1:0]   tb16 [0:1];
        logic [2*W2+1:0] exp;
        int              n;
        tb16 = '{16'd1, 16'd255};
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            signed16 = 1'b0; dividend16 = 16'd255; divisor16 = tb16[i]; start16 = 1'b1;
            exp16_q.push_back({16'd255 / tb16[i], 16'd255 % tb16[i], 2'b00});
            @(posedge clk); #1;
            start16 = 1'b0;
            n = 0;
            while (n < 64) begin
                @(posedge clk); n++; #1;
                if (done16) break;
            end
            exp = exp16_q.pop_front();
            n_checks++; if (n != W2 + 1) begin n_fail++; $display("FAIL wide_latency 255/%0d: got %0d cycles expected %0d", tb16[i], n, W2 + 1); end
            n_checks++; if ({quotient16, remainder16, dbz16, ovf16} !== exp) begin n_fail++; $display("FAIL wide_result 255/%0d: got %h expected %h", tb16[i], {quotient16, remainder16, dbz16, ovf16}, exp); end
        end
    endtask

    initial begin
        test_reset();
        test_unsigned();
        test_signed();
        test_flags();
        test_busy_ignore();
        test_mid_reset();
        test_back_to_back();
        test_wide();
        n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size()); end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
